// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared digit count and 7-segment lookup for the display scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] digit_idx_t;

    // Index 0 is the rightmost entry; codes 10-15 show a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

`default_nettype wire

// File: rtl/disp_scan_if.sv
// ============================================================================
// disp_scan_if : time digits / edit flags / alarm in, digit drive and buzzer out
// Rev 1.0
// ============================================================================
`default_nettype none

interface disp_scan_if;
    logic [3:0] hour_t;
    logic [3:0] hour_s;
    logic [3:0] minute_t;
    logic [3:0] minute_s;
    logic [3:0] second_t;
    logic [3:0] second_s;
    logic       LD_h;
    logic       LD_m;
    logic       alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       buzzer;

    modport master (
        output hour_t, hour_s, minute_t, minute_s, second_t, second_s,
        output LD_h, LD_m, alarm,
        input  an, seg, dp, buzzer
    );

    modport slave (
        input  hour_t, hour_s, minute_t, minute_s, second_t, second_s,
        input  LD_h, LD_m, alarm,
        output an, seg, dp, buzzer
    );
endinterface

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : combinational BCD to {g,f,e,d,c,b,a} segment decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import clock_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[bcd];
    end

endmodule

`default_nettype wire

// File: rtl/disp_scan.sv
// ============================================================================
// disp_scan : six-digit multiplexed display scanner with edit blink and buzzer
// Rev 1.0
// ============================================================================
`default_nettype none

module disp_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int BEEP_DIV     = 2000
)(
    input  logic       clk_lk,
    input  logic       reset,
    disp_scan_if.slave bus
);

    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);
    localparam int BEEP_W = $clog2(BEEP_DIV);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [FRM_W-1:0]  FRM_ONE   = FRM_W'(1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);
    localparam digit_idx_t        IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]               r_pre;
    logic [FRM_W-1:0]               r_frm;
    logic [BEEP_W-1:0]              r_beep;
    digit_idx_t                     r_idx;
    logic                           r_phase;
    logic                           r_alarm_q;
    logic                           r_buzzer;
    logic [5:0]                     r_an;
    logic [6:0]                     r_seg;
    logic                           r_dp;
    logic [NUM_DIGITS-1:0][3:0]     r_snap;

    logic                           w_tick;
    logic                           w_wrap;
    logic                           w_frame_wrap;
    logic                           w_phase_next;
    logic                           w_blank;
    digit_idx_t                     w_idx_next;
    bcd_t                           w_digit;
    logic [6:0]                     w_dec_seg;
    logic [NUM_DIGITS-1:0][3:0]     w_in;

    assign w_in = {bus.second_s, bus.second_t, bus.minute_s,
                   bus.minute_t, bus.hour_s,   bus.hour_t};

    assign w_tick       = (r_pre == PRE_LAST);
    assign w_wrap       = w_tick && (r_idx == IDX_LAST);
    assign w_frame_wrap = w_wrap && (r_frm == FRM_LAST);
    assign w_phase_next = r_phase ^ w_frame_wrap;
    assign w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 3'd1;

    // On a frame wrap the snapshot loads on this same edge, so digit 0 is
    // taken straight from the inputs that are being captured.
    assign w_digit = w_wrap ? w_in[w_idx_next] : r_snap[w_idx_next];

    // Edit flags are live (not snapshotted) so blanking reacts within a slot.
    assign w_blank = w_phase_next &&
                     ((bus.LD_h && (w_idx_next <= 3'd1)) ||
                      (bus.LD_m && ((w_idx_next == 3'd2) || (w_idx_next == 3'd3))));

    seg7_decode u_dec (
        .bcd (w_digit),
        .seg (w_dec_seg)
    );

    always_ff @(posedge clk_lk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frm   <= '0;
            r_phase <= 1'b0;
            r_snap  <= '0;
            r_an    <= 6'b111111;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_ONE;
            if (w_tick) begin
                r_idx <= w_idx_next;
                r_an  <= ~(6'b000001 << w_idx_next);
                r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
                r_dp  <= ~w_blank && ((w_idx_next == 3'd1) || (w_idx_next == 3'd3));
            end
            if (w_wrap) begin
                r_snap  <= w_in;
                r_frm   <= w_frame_wrap ? '0 : r_frm + FRM_ONE;
                r_phase <= w_phase_next;
            end
        end
    end

    // Beep path runs on its own counter so alarm activity never shifts the scan.
    always_ff @(posedge clk_lk or posedge reset) begin
        if (reset) begin
            r_alarm_q <= 1'b0;
            r_beep    <= '0;
            r_buzzer  <= 1'b0;
        end else begin
            r_alarm_q <= bus.alarm;
            if (r_alarm_q) begin
                if (r_beep == BEEP_LAST) begin
                    r_beep   <= '0;
                    r_buzzer <= ~r_buzzer;
                end else begin
                    r_beep <= r_beep + BEEP_ONE;
                end
            end else begin
                r_beep   <= '0;
                r_buzzer <= 1'b0;
            end
        end
    end

    assign bus.an     = r_an;
    assign bus.seg    = r_seg;
    assign bus.dp     = r_dp;
    assign bus.buzzer = r_buzzer;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan.sv
// ============================================================================
// tb_disp_scan : scoreboard bench for disp_scan (SCAN_DIV=4, BLINK_FRAMES=2, BEEP_DIV=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_disp_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int BEEP_DIV     = 3;
    localparam int FRAME_CYC    = SCAN_DIV * 6;

    logic clk_lk;
    logic rst;

    disp_scan_if bus ();

    disp_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BEEP_DIV     (BEEP_DIV)
    ) u_dut (
        .clk_lk (clk_lk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk_lk = 1'b0;
    always #5 clk_lk = ~clk_lk;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       buz;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Reference model: timing is derived from edge counts since reset release.
    int         e_cnt = 0;
    int         m_idx = 0;
    int         m_run = 0;
    logic       m_aq  = 1'b0;
    logic       m_buz = 1'b0;
    logic [3:0] m_snap [6];
    logic [5:0] e_an  = 6'h3F;
    logic [6:0] e_seg = 7'h00;
    logic       e_dp  = 1'b0;

    initial begin
        int n, w, phase;
        logic blank;
        foreach (m_snap[i]) m_snap[i] = 4'h0;
        forever begin
            @(posedge clk_lk or posedge rst);
            if (rst) begin
                e_cnt = 0; m_idx = 0; m_run = 0; m_aq = 1'b0; m_buz = 1'b0;
                e_an = 6'h3F; e_seg = 7'h00; e_dp = 1'b0;
                foreach (m_snap[i]) m_snap[i] = 4'h0;
                sb_q.delete();
            end else begin
                e_cnt++;
                if (e_cnt % SCAN_DIV == 0) begin
                    n     = e_cnt / SCAN_DIV;
                    m_idx = n % 6;
                    if (m_idx == 0) begin
                        m_snap[0] = bus.hour_t;   m_snap[1] = bus.hour_s;
                        m_snap[2] = bus.minute_t; m_snap[3] = bus.minute_s;
                        m_snap[4] = bus.second_t; m_snap[5] = bus.second_s;
                    end
                    w     = n / 6;
                    phase = (w / BLINK_FRAMES) % 2;
                    blank = (phase == 1) &&
                            ((bus.LD_h && m_idx < 2) || (bus.LD_m && (m_idx == 2 || m_idx == 3)));
                    e_an = 6'h3F;
                    e_an[m_idx] = 1'b0;
                    e_seg = blank ? 7'h00 : seg_of(m_snap[m_idx]);
                    e_dp  = !blank && (m_idx == 1 || m_idx == 3);
                end
                if (m_aq) begin
                    m_run++;
                    m_buz = ((m_run / BEEP_DIV) % 2) == 1;
                end else begin
                    m_run = 0;
                    m_buz = 1'b0;
                end
                m_aq = bus.alarm;
                sb_q.push_back('{an: e_an, seg: e_seg, dp: e_dp, buz: m_buz});
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_lk);
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("an",     32'(bus.an),     32'(e.an));
                check("seg",    32'(bus.seg),    32'(e.seg));
                check("dp",     32'(bus.dp),     32'(e.dp));
                check("buzzer", 32'(bus.buzzer), 32'(e.buz));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk_lk);
    endtask

    task automatic wait_idx(input int target);
        int k = 0;
        do begin
            @(negedge clk_lk);
            k++;
        end while (m_idx != target && k < 64);
        check("wait_idx", 32'(m_idx), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  32'(bus.an),     32'h3F);
        check({tag, "_seg"}, 32'(bus.seg),    32'h00);
        check({tag, "_dp"},  32'(bus.dp),     32'h0);
        check({tag, "_buz"}, 32'(bus.buzzer), 32'h0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.hour_t = 4'd1; bus.hour_s = 4'd2; bus.minute_t = 4'd3;
        bus.minute_s = 4'd4; bus.second_t = 4'd5; bus.second_s = 4'd6;
        bus.LD_h = 1'b0; bus.LD_m = 1'b0; bus.alarm = 1'b0;
        run(3);
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        // Frame 1 shows zeros, frame 2 shows 1..6 with separators.
        run(2 * FRAME_CYC);

        // Mid-frame change must not tear the current frame.
        wait_idx(1);
        bus.minute_s = 4'd7;
        run(2 * FRAME_CYC);

        // Non-BCD value renders as a dash.
        bus.hour_t = 4'hC;
        run(2 * FRAME_CYC);

        bus.LD_h = 1'b1;
        run(5 * FRAME_CYC);
        bus.LD_h = 1'b0;
        bus.LD_m = 1'b1;
        run(4 * FRAME_CYC + 7);
        bus.LD_h = 1'b1;
        run(4 * FRAME_CYC);
        bus.LD_h = 1'b0;
        bus.LD_m = 1'b0;
        run(FRAME_CYC);

        bus.alarm = 1'b1;
        run(20);
        bus.alarm = 1'b0;
        run(10);
        bus.alarm = 1'b1;
        run(11);
        bus.alarm = 1'b0;
        run(10);

        // Asynchronous reset while digit 3 is lit and the buzzer is high.
        bus.alarm = 1'b1;
        k = 0;
        do begin
            @(negedge clk_lk);
            k++;
        end while (!(m_idx == 3 && m_buz == 1'b1) && k < 300);
        check("pre_rst_buzzer", 32'(bus.buzzer), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk_lk);
        bus.alarm = 1'b0;
        run(2);
        check_reset_outputs("rst_hold2");
        rst = 1'b0;
        run(3 * FRAME_CYC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
